key_code_arbiter: RTL

Shares the single key-code sound channel between one live keyboard source and several demo-song players. Each demo player is sequenced through a per-source run line that holds it in restart while not granted, so its note list restarts from step 0 on every grant. The arbiter forwards the granted source's 8-bit key code to the synth. It inserts a forced key-release gap (8'hf0) between ownership changes so no note hangs across a handover.

---
 rtl/key_code_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/key_code_arbiter.sv
// Arbitrates one synth key-code channel between a live keyboard (source 0) and demo players,
// inserting a forced release gap between owners and ending silent grants by timeout.
module key_code_arbiter #(
  parameter int NUM_SRC      = 3,
  parameter int GAP_CYCLES   = 16,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         req,
  input  logic [8*NUM_SRC-1:0]       src_code,
  output logic [NUM_SRC-1:0]         run,
  output logic [7:0]                 key_code,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy,
  output logic [NUM_SRC-1:0]         done
);

  localparam int GW  = $clog2(NUM_SRC);
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [7:0] RELEASE = 8'hf0;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_t;

  state_t             state_reg;
  logic [GW-1:0]      last_rr_reg;
  logic [7:0]         idle_cnt_reg;
  logic [GCW-1:0]     gap_cnt_reg;
  logic [NUM_SRC-1:0] blocked_reg;

  logic [7:0]         code_arr [NUM_SRC];
  logic [NUM_SRC-1:0] eligible;
  logic               any_elig;
  logic [GW-1:0]      winner;
  logic [7:0]         cur_code;
  logic               cur_release;
  logic               req_drop;
  logic               timeout_hit;
  logic               preempt;
  logic               grant_exit;
  logic [NUM_SRC-1:0] owner_mask;
  logic [NUM_SRC-1:0] timeout_mask;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign code_arr[gi] = src_code[8*gi +: 8];
    end
  endgenerate

  assign eligible    = req & ~blocked_reg;
  assign cur_code    = code_arr[grant_id];
  assign cur_release = (cur_code == RELEASE);
  assign owner_mask  = NUM_SRC'(1) << grant_id;

  assign req_drop     = ~req[grant_id];
  // Counter holds the f0 cycles already seen, so this cycle is the IDLE_TIMEOUT-th one.
  assign timeout_hit  = cur_release && (idle_cnt_reg == 8'(IDLE_TIMEOUT - 1));
  assign preempt      = (grant_id != '0) && req[0] && cur_release;
  assign grant_exit   = req_drop || timeout_hit || preempt;
  assign timeout_mask = (state_reg == ST_GRANT && timeout_hit) ? owner_mask : '0;

  // Keyboard has absolute priority; demo players rotate starting after the last demo owner.
  always_comb begin
    int            idx;
    logic [GW-1:0] idx_v;
    any_elig = 1'b0;
    winner   = '0;
    idx      = 0;
    idx_v    = '0;
    if (eligible[0]) begin
      any_elig = 1'b1;
    end else begin
      for (int k = 0; k < NUM_SRC - 1; k++) begin
        idx = int'(last_rr_reg) + 1 + k;
        if (idx >= NUM_SRC) idx = idx - (NUM_SRC - 1);
        idx_v = GW'(idx);
        if (!any_elig && eligible[idx_v]) begin
          any_elig = 1'b1;
          winner   = idx_v;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      run          <= '0;
      key_code     <= RELEASE;
      grant_id     <= '0;
      busy         <= 1'b0;
      done         <= '0;
      last_rr_reg  <= '0;
      idle_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      blocked_reg  <= '0;
    end else begin
      done <= timeout_mask;
      // A dropped request always unblocks, even in the same cycle as a timeout.
      blocked_reg <= (blocked_reg | timeout_mask) & req;
      case (state_reg)
        ST_IDLE: begin
          key_code <= RELEASE;
          run      <= '0;
          if (any_elig) begin
            state_reg    <= ST_GRANT;
            run          <= NUM_SRC'(1) << winner;
            grant_id     <= winner;
            busy         <= 1'b1;
            idle_cnt_reg <= '0;
            if (winner != '0) last_rr_reg <= winner;
          end
        end
        ST_GRANT: begin
          if (grant_exit) begin
            state_reg    <= ST_GAP;
            run          <= '0;
            key_code     <= RELEASE;
            gap_cnt_reg  <= '0;
            idle_cnt_reg <= '0;
          end else begin
            key_code <= cur_code;
            if (!cur_release)
              idle_cnt_reg <= '0;
            else if (idle_cnt_reg < 8'(IDLE_TIMEOUT))
              idle_cnt_reg <= idle_cnt_reg + 8'd1;
          end
        end
        ST_GAP: begin
          key_code <= RELEASE;
          run      <= '0;
          if (gap_cnt_reg == GCW'(GAP_CYCLES - 1)) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GCW'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          run       <= '0;
          key_code  <= RELEASE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
